imem_server: RTL and testbench

Instruction-memory responder for the SEQ Y86-64 core. It owns the program byte store and answers fetch requests from the processor's fetch stage. For each request it returns a 10-byte instruction window plus an imem_error flag. The program is first streamed in, one byte per cycle, through a load port; fetch service starts only once loading has finished.

---
 rtl/imem_pkg.sv | 23 ++
 rtl/imem_ram.sv | 24 ++
 rtl/imem_server.sv | 123 ++++++++++++
 tb/tb_imem_server.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared types and constants for the Y86-64 instruction-memory server.
package imem_pkg;

   localparam int FETCH_BYTES = 10;
   localparam int INSTR_W     = 8 * FETCH_BYTES;
   localparam int CNT_W       = $clog2(FETCH_BYTES);

   typedef enum logic [1:0] {
      ST_LOAD,
      ST_IDLE,
      ST_READ,
      ST_RESP
   } state_e;

   // Encoded to match the core's stat register.
   typedef enum logic [2:0] {
      STAT_AOK = 3'd1,
      STAT_HLT = 3'd2,
      STAT_ADR = 3'd3,
      STAT_INS = 3'd4
   } stat_e;

endpackage

// File: rtl/imem_ram.sv
// Program byte store: one synchronous write port, one asynchronous read port.
module imem_ram #(
   parameter int DEPTH = 1024,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [7:0]    i_wdata,
   input  logic [AW-1:0] i_raddr,
   output logic [7:0]    o_rdata
);

   logic [7:0] r_mem [DEPTH];

   // NOTE: the store has no reset; contents must survive rst_n and a reset
   // port would also stop the array mapping onto RAM macros.
   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/imem_server.sv
// Instruction-memory responder: streams in the program, then serves
// 10-byte fetch windows one byte per cycle with an address-range error flag.
module imem_server
   import imem_pkg::*;
#(
   parameter int MEM_BYTES = 1024
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               ld_valid,
   output logic               ld_ready,
   input  logic [7:0]         ld_byte,
   input  logic               ld_last,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [63:0]        req_pc,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [INSTR_W-1:0] rsp_instr,
   output logic               rsp_imem_error,
   output logic               loaded,
   output logic               busy
);

   localparam int          AW      = $clog2(MEM_BYTES);
   localparam logic [63:0] LAST_PC = 64'(MEM_BYTES - FETCH_BYTES);

   state_e             r_state, w_next;
   logic [AW-1:0]      r_wptr;
   logic [AW-1:0]      r_pc;     // only the in-range part of pc_q is ever read
   logic [CNT_W-1:0]   r_cnt;
   logic [INSTR_W-1:0] r_window;
   stat_e              r_stat;

   logic          w_ld_fire, w_ld_done, w_req_fire, w_rsp_fire;
   logic          w_pc_err, w_read_last;
   logic [AW-1:0] w_rd_addr;
   logic [7:0]    w_rd_byte;

   assign w_ld_fire   = ld_valid  && (r_state == ST_LOAD);
   assign w_ld_done   = w_ld_fire && (ld_last || (r_wptr == AW'(MEM_BYTES - 1)));
   assign w_req_fire  = req_valid && (r_state == ST_IDLE);
   assign w_rsp_fire  = rsp_ready && (r_state == ST_RESP);
   assign w_pc_err    = req_pc > LAST_PC;
   assign w_read_last = r_cnt == CNT_W'(FETCH_BYTES - 1);
   assign w_rd_addr   = r_pc + AW'(r_cnt);

   imem_ram #(.DEPTH(MEM_BYTES), .AW(AW)) u_ram (
      .clk     (clk),
      .i_we    (w_ld_fire),
      .i_waddr (r_wptr),
      .i_wdata (ld_byte),
      .i_raddr (w_rd_addr),
      .o_rdata (w_rd_byte)
   );

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values of the others.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_LOAD;
      else        r_state <= w_next;
   end

   // NOTE: every output and w_next gets a default first, so no path can
   // leave them unassigned and infer a latch.
   always_comb begin
      w_next    = r_state;
      ld_ready  = 1'b0;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      loaded    = 1'b1;
      busy      = 1'b0;
      unique case (r_state)
         ST_LOAD: begin
            ld_ready = 1'b1;
            loaded   = 1'b0;
            if (w_ld_done) w_next = ST_IDLE;
         end
         ST_IDLE: begin
            req_ready = 1'b1;
            if (w_req_fire) w_next = w_pc_err ? ST_RESP : ST_READ;
         end
         ST_READ: begin
            busy = 1'b1;
            if (w_read_last) w_next = ST_RESP;
         end
         ST_RESP: begin
            busy      = 1'b1;
            rsp_valid = 1'b1;
            if (w_rsp_fire) w_next = ST_IDLE;
         end
         default: w_next = ST_LOAD;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr   <= '0;
         r_pc     <= '0;
         r_cnt    <= '0;
         r_window <= '0;
         r_stat   <= STAT_AOK;
      end else begin
         if (w_ld_fire) r_wptr <= r_wptr + AW'(1);
         if (w_req_fire) begin
            r_pc     <= req_pc[AW-1:0];
            r_cnt    <= '0;
            r_window <= '0;
            r_stat   <= w_pc_err ? STAT_ADR : STAT_AOK;
         end
         if (r_state == ST_READ) begin
            for (int k = 0; k < FETCH_BYTES; k++) begin
               if (r_cnt == CNT_W'(k)) r_window[8*k +: 8] <= w_rd_byte;
            end
            r_cnt <= w_read_last ? '0 : r_cnt + CNT_W'(1);
         end
      end
   end

   assign rsp_instr      = r_window;
   assign rsp_imem_error = (r_stat == STAT_ADR);

endmodule

// File: tb/tb_imem_server.sv
// Scoreboard bench for imem_server: expected windows are pushed on request
// accept and popped at the response handshake.
module tb_imem_server;
   import imem_pkg::*;

   localparam int MEM_BYTES = 1024;

   logic               clk       = 1'b0;
   logic               rst_n     = 1'b0;
   logic               ld_valid  = 1'b0;
   logic [7:0]         ld_byte   = '0;
   logic               ld_last   = 1'b0;
   logic               req_valid = 1'b0;
   logic [63:0]        req_pc    = '0;
   logic               rsp_ready = 1'b0;
   logic               ld_ready, req_ready, rsp_valid, rsp_imem_error, loaded, busy;
   logic [INSTR_W-1:0] rsp_instr;

   imem_server #(.MEM_BYTES(MEM_BYTES)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .ld_valid       (ld_valid),
      .ld_ready       (ld_ready),
      .ld_byte        (ld_byte),
      .ld_last        (ld_last),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_pc         (req_pc),
      .rsp_valid      (rsp_valid),
      .rsp_ready      (rsp_ready),
      .rsp_instr      (rsp_instr),
      .rsp_imem_error (rsp_imem_error),
      .loaded         (loaded),
      .busy           (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [INSTR_W-1:0] instr;
      logic               err;
   } exp_t;

   exp_t       sb_q [$];
   logic [7:0] model [MEM_BYTES];
   int         wp     = 0;
   int         n_cmp  = 0;
   int         n_mis  = 0;

   task automatic check(input string tag, input logic [INSTR_W-1:0] got,
                        input logic [INSTR_W-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic check_reset_outs(input string pfx);
      check({pfx, "_ld_ready"},  ld_ready,       1);
      check({pfx, "_req_ready"}, req_ready,      0);
      check({pfx, "_rsp_valid"}, rsp_valid,      0);
      check({pfx, "_err"},       rsp_imem_error, 0);
      check({pfx, "_instr"},     rsp_instr,      0);
      check({pfx, "_loaded"},    loaded,         0);
      check({pfx, "_busy"},      busy,           0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_reset_outs("rst");
      @(negedge clk);
      rst_n = 1'b1;
      wp    = 0;
   endtask

   // Streams bytes into LOAD; ld_last only on the final byte when use_last.
   task automatic load_seq(input logic [7:0] bytes [$], input bit use_last);
      for (int i = 0; i < bytes.size(); i++) begin
         @(negedge clk);
         if (i == 0) check("ld_ready_load", ld_ready, 1);
         if (i == bytes.size() - 1) begin
            check("loaded_before_last", loaded, 0);
            check("req_ready_in_load", req_ready, 0);
         end
         ld_valid  = 1'b1;
         ld_byte   = bytes[i];
         ld_last   = use_last && (i == bytes.size() - 1);
         model[wp] = bytes[i];
         wp++;
      end
      @(negedge clk);
      ld_valid  = 1'b0;
      ld_last   = 1'b0;
      req_valid = 1'b0;
      check("loaded_after_last", loaded, 1);
      check("ld_ready_after_load", ld_ready, 0);
   endtask

   task automatic fetch(input logic [63:0] pc, input int hold);
      exp_t               e;
      int                 waited;
      int                 lat;
      logic [INSTR_W-1:0] snap;
      e.err   = pc > 64'(MEM_BYTES - FETCH_BYTES);
      e.instr = '0;
      if (!e.err)
         for (int k = 0; k < FETCH_BYTES; k++) e.instr[8*k +: 8] = model[int'(pc) + k];

      @(negedge clk);
      waited = 0;
      while (!req_ready && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      check("req_ready_idle", req_ready, 1);
      req_valid = 1'b1;
      req_pc    = pc;
      @(posedge clk);
      sb_q.push_back(e);
      @(negedge clk);
      req_valid = 1'b0;
      lat = 1;
      while (!rsp_valid && lat < 30) begin
         @(negedge clk);
         lat++;
      end
      check("rsp_latency", lat, e.err ? 1 : FETCH_BYTES + 1);
      check("busy_resp", busy, 1);
      snap = rsp_instr;
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         check("hold_valid", rsp_valid, 1);
         check("hold_instr", rsp_instr, snap);
         check("hold_req_ready", req_ready, 0);
      end
      rsp_ready = 1'b1;
      check("sb_depth", sb_q.size(), 1);
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         check("rsp_instr", rsp_instr, e.instr);
         check("rsp_err", rsp_imem_error, e.err);
      end
      @(negedge clk);
      rsp_ready = 1'b0;
      check("single_handshake", rsp_valid, 0);
      check("req_ready_back", req_ready, 1);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] prog   [$];
      logic [7:0] stream [$];
      int         stray;

      repeat (2) @(negedge clk);
      check_reset_outs("por");
      rst_n = 1'b1;

      // Short program; a competing fetch request must be ignored in LOAD.
      prog      = '{8'h30, 8'h00, 8'hF3, 8'h0A, 8'h00, 8'h00,
                    8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      req_valid = 1'b1;
      req_pc    = '0;
      load_seq(prog, 1'b1);
      check("no_rsp_after_load", rsp_valid, 0);

      fetch(64'd0, 0);
      fetch(64'd1015, 0);
      fetch(64'hFFFF_FFFF_FFFF_FFFF, 5);
      fetch(64'd2, 5);

      // Full-length stream with no ld_last: auto-exit at the last address.
      do_reset();
      stream = {};
      for (int i = 0; i < MEM_BYTES; i++) stream.push_back(8'($urandom_range(0, 255)));
      load_seq(stream, 1'b0);
      ld_valid = 1'b1;
      ld_byte  = 8'hEE;
      fetch(64'd0, 0);
      ld_valid = 1'b0;
      check("ld_ready_stays_low", ld_ready, 0);
      fetch(64'd1014, 0);
      fetch(64'd1015, 0);
      fetch(64'd500, 3);

      // Reset in the 4th READ cycle aborts the fetch with no response.
      @(negedge clk);
      req_valid = 1'b1;
      req_pc    = '0;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("busy_mid_read", busy, 1);
      rst_n = 1'b0;
      #1;
      check_reset_outs("mid_read_rst");
      @(negedge clk);
      rst_n = 1'b1;
      wp    = 0;
      stray = 0;
      for (int c = 0; c < 15; c++) begin
         @(negedge clk);
         if (rsp_valid) stray++;
      end
      check("no_rsp_after_abort", stray, 0);

      // Partial reload; bytes 3..9 must still hold the streamed data.
      prog = '{8'h10, 8'h20, 8'h00};
      load_seq(prog, 1'b1);
      fetch(64'd0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
